program_sequencer_ws: RTL and testbench

// Parametrised next-generation program sequencer for the microprocessor core. Generates the program-memory

---
 rtl/program_sequencer_pkg.sv | 19 +
 rtl/program_sequencer_ws_return_stack.sv | 64 ++++++
 rtl/program_sequencer_ws.sv | 152 +++++++++++++++
 tb/tb_program_sequencer_ws.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared types and sizing helpers for the program sequencer
package program_sequencer_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } seq_state_t;

    // Stack pointer must represent 0..depth inclusive
    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Wait counter must hold the load value; keep at least one bit when no wait states are used
    function automatic int cnt_width(input int wait_states);
        return (wait_states < 1) ? 1 : $clog2(wait_states + 1);
    endfunction

endpackage

// File: rtl/program_sequencer_ws_return_stack.sv
// rtl/program_sequencer_ws_return_stack.sv - LIFO holding call return addresses
module return_stack #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 4,
    parameter int SP_W   = 3
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty,
    output logic [SP_W-1:0]   count
);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0]   count_q;
    logic [SP_W-1:0]   count_d;

    assign full  = (count_q == SP_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Occupancy update; a push into a full stack or a pop from an empty one is dropped
    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + SP_W'(1);
        end else if (pop && !empty) begin
            count_d = count_q - SP_W'(1);
        end
    end

    // Only the pointer is reset; entry contents are meaningless once the pointer is cleared
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Write the new entry into the slot just above the current top
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push && !full && !sync_reset && (count_q == SP_W'(i))) begin
                mem_q[i] <= push_data;
            end
        end
    end

    // Top-of-stack read; reads as zero when empty so debug visibility is clean
    always_comb begin
        top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == SP_W'(i + 1)) begin
                top = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/program_sequencer_ws.sv
// rtl/program_sequencer_ws.sv - program sequencer with return stack and wait-state engine
module program_sequencer_ws
    import program_sequencer_pkg::*;
#(
    parameter int                ADDR_W      = 8,
    parameter int                STACK_DEPTH = 4,
    parameter int                WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    localparam int               SP_W        = sp_width(STACK_DEPTH)
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic              jump,
    input  logic              conditional_jump,
    input  logic              dont_jump_flag,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pm_address,
    output logic [ADDR_W-1:0] pc,
    output logic              stall,
    output logic [SP_W-1:0]   sp,
    output logic [ADDR_W-1:0] from_PS,
    output logic              stack_overflow,
    output logic              stack_underflow
);

    localparam int               CNT_W     = cnt_width(WAIT_STATES);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

    seq_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] next_addr;
    logic              run;
    logic              do_ret;
    logic              do_call;
    logic              stk_push;
    logic              stk_pop;
    logic              stk_full;
    logic              stk_empty;
    logic [ADDR_W-1:0] stk_top;
    logic [SP_W-1:0]   stk_count;

    assign run    = (state_q == RUN);
    assign pc_inc = pc_q + ADDR_W'(1);

    // Strobe decode: ret outranks call, and strobes only count in a RUN slot outside reset
    always_comb begin
        do_ret   = run && ret && !sync_reset;
        do_call  = run && call && !ret && !sync_reset;
        stk_pop  = do_ret && !stk_empty;
        stk_push = do_call && !stk_full;
    end

    // Address selection by priority: reset, ret, call/jump/taken conditional, sequential
    always_comb begin
        next_addr = pc_inc;
        if (sync_reset) begin
            next_addr = RESET_ADDR;
        end else if (ret) begin
            next_addr = stk_empty ? pc_inc : stk_top;
        end else if (call || jump || (conditional_jump && !dont_jump_flag)) begin
            next_addr = jump_addr;
        end
    end

    return_stack #(
        .ADDR_W (ADDR_W),
        .DEPTH  (STACK_DEPTH),
        .SP_W   (SP_W)
    ) u_stack (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (stk_push),
        .pop        (stk_pop),
        .push_data  (pc_inc),
        .top        (stk_top),
        .full       (stk_full),
        .empty      (stk_empty),
        .count      (stk_count)
    );

    // State register: fetch FSM, program counter and sticky fault flags
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            pc_q    <= RESET_ADDR;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Next state: RUN advances the pc and opens a wait window; WAIT counts it down
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            RUN: begin
                pc_d = next_addr;
                if (do_ret && stk_empty) begin
                    unf_d = 1'b1;
                end
                if (do_call && stk_full) begin
                    ovf_d = 1'b1;
                end
                if (WAIT_STATES > 0) begin
                    state_d = WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Outputs: hold the fetch address while the ROM access is in progress
    always_comb begin
        stall      = !run;
        pm_address = pc_q;
        if (run || sync_reset) begin
            pm_address = next_addr;
        end
    end

    assign pc              = pc_q;
    assign sp              = stk_count;
    assign from_PS         = stk_top;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_program_sequencer_ws.sv
// tb/tb_program_sequencer_ws.sv - scoreboard bench for program_sequencer_ws
module tb_program_sequencer_ws;

    logic       clk = 1'b0;
    logic       sync_reset, jump, conditional_jump, dont_jump_flag, call, ret;
    logic [7:0] jump_addr;

    logic [7:0] pm0, pc0, fps0, pm2, pc2, fps2;
    logic       stall0, ovf0, unf0, stall2, ovf2, unf2;
    logic [2:0] sp0, sp2;

    typedef struct {
        logic [29:0] exp;
        bit          which;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    program_sequencer_ws #(.ADDR_W(8), .STACK_DEPTH(4), .WAIT_STATES(0), .RESET_ADDR(8'h00)) dut0 (
        .clk(clk), .sync_reset(sync_reset), .jump(jump), .conditional_jump(conditional_jump),
        .dont_jump_flag(dont_jump_flag), .call(call), .ret(ret), .jump_addr(jump_addr),
        .pm_address(pm0), .pc(pc0), .stall(stall0), .sp(sp0), .from_PS(fps0),
        .stack_overflow(ovf0), .stack_underflow(unf0)
    );

    program_sequencer_ws #(.ADDR_W(8), .STACK_DEPTH(4), .WAIT_STATES(2), .RESET_ADDR(8'h00)) dut2 (
        .clk(clk), .sync_reset(sync_reset), .jump(jump), .conditional_jump(conditional_jump),
        .dont_jump_flag(dont_jump_flag), .call(call), .ret(ret), .jump_addr(jump_addr),
        .pm_address(pm2), .pc(pc2), .stall(stall2), .sp(sp2), .from_PS(fps2),
        .stack_overflow(ovf2), .stack_underflow(unf2)
    );

    function automatic logic [29:0] obs(input bit which);
        if (which) return {pm2, pc2, stall2, sp2, fps2, ovf2, unf2};
        return {pm0, pc0, stall0, sp0, fps0, ovf0, unf0};
    endfunction

    function automatic logic [29:0] ex(input logic [7:0] pm, input logic [7:0] pcv, input logic st,
                                       input logic [2:0] spv, input logic [7:0] fps,
                                       input logic ovf, input logic unf);
        return {pm, pcv, st, spv, fps, ovf, unf};
    endfunction

    task automatic drive(input logic rst, input logic jmp, input logic cj, input logic djf,
                         input logic cl, input logic rt, input logic [7:0] addr);
        sync_reset       = rst;
        jump             = jmp;
        conditional_jump = cj;
        dont_jump_flag   = djf;
        call             = cl;
        ret              = rt;
        jump_addr        = addr;
    endtask

    task automatic apply_reset();
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        sb_t e;
        drive(1, 1, 1, 0, 1, 1, 8'h55);
        @(posedge clk); #1;
        sb.push_back('{exp: ex(8'h00, 8'h00, 0, 3'd0, 8'h00, 0, 0), which: 1'b0});
        sb.push_back('{exp: ex(8'h00, 8'h00, 0, 3'd0, 8'h00, 0, 0), which: 1'b1});
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL reset dut%0d got %h want %h", e.which ? 2 : 0, obs(e.which), e.exp);
            end
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_count_wrap();
        sb_t e;
        apply_reset();
        for (int k = 0; k < 260; k++) begin
            sb.push_back('{exp: ex(8'(k + 1), 8'(k), 0, 3'd0, 8'h00, 0, 0), which: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL count[%0d] got %h want %h", k, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_states();
        sb_t        e;
        int         s, ph;
        logic [7:0] cur, nxt;
        apply_reset();
        for (int k = 0; k < 18; k++) begin
            s   = k / 3;
            ph  = k % 3;
            cur = (s == 5) ? 8'h90 : 8'(s);
            nxt = (s == 4) ? 8'h90 : (s == 5) ? 8'h91 : 8'(s + 1);
            if (s == 3 && ph != 0)      drive(0, 1, 0, 0, 0, 0, 8'h80);
            else if (s == 4 && ph == 0) drive(0, 1, 0, 0, 0, 0, 8'h90);
            else                        drive(0, 0, 0, 0, 0, 0, 8'h00);
            if (ph == 0) sb.push_back('{exp: ex(nxt, cur, 0, 3'd0, 8'h00, 0, 0), which: 1'b1});
            else         sb.push_back('{exp: ex(nxt, nxt, 1, 3'd0, 8'h00, 0, 0), which: 1'b1});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL wait[%0d] got %h want %h", k, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_call_ret();
        sb_t         e;
        logic [29:0] x;
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            x = '0;
            case (k)
                0: begin drive(0, 1, 0, 0, 0, 0, 8'h10); x = ex(8'h10, 8'h00, 0, 3'd0, 8'h00, 0, 0); end
                1: begin drive(0, 0, 0, 0, 1, 0, 8'h40); x = ex(8'h40, 8'h10, 0, 3'd0, 8'h00, 0, 0); end
                2: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h41, 8'h40, 0, 3'd1, 8'h11, 0, 0); end
                3: begin drive(0, 0, 0, 0, 0, 1, 8'h00); x = ex(8'h11, 8'h41, 0, 3'd1, 8'h11, 0, 0); end
                default: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h12, 8'h11, 0, 3'd0, 8'h00, 0, 0); end
            endcase
            sb.push_back('{exp: x, which: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL call_ret[%0d] got %h want %h", k, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_overflow_underflow();
        sb_t        e;
        logic [7:0] ra [4];
        logic [7:0] pcx, pmx, fpx;
        for (int k = 0; k < 4; k++) ra[k] = (k == 0) ? 8'h01 : 8'(8'h31 + 8'h10 * k);
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 8'(8'h40 + 8'h10 * i));
            pcx = (i == 0) ? 8'h00 : 8'(8'h40 + 8'h10 * (i - 1));
            fpx = (i == 0) ? 8'h00 : ra[i - 1];
            sb.push_back('{exp: ex(8'(8'h40 + 8'h10 * i), pcx, 0, 3'(i), fpx, 0, 0), which: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL ovf_call[%0d] got %h want %h", i, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
        for (int j = 0; j < 6; j++) begin
            if (j < 5) drive(0, 0, 0, 0, 0, 1, 8'h00);
            else       drive(0, 0, 0, 0, 0, 0, 8'h00);
            if (j < 5) begin
                pcx = (j == 0) ? 8'h80 : ra[4 - j];
                fpx = (j < 4) ? ra[3 - j] : 8'h00;
                pmx = (j < 4) ? ra[3 - j] : 8'(pcx + 1);
                sb.push_back('{exp: ex(pmx, pcx, 0, 3'(4 - j), fpx, 1, 0), which: 1'b0});
            end else begin
                sb.push_back('{exp: ex(8'h03, 8'h02, 0, 3'd0, 8'h00, 1, 1), which: 1'b0});
            end
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL unf_ret[%0d] got %h want %h", j, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_conditional();
        sb_t         e;
        logic [29:0] x;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            x = '0;
            case (k)
                0: begin drive(0, 0, 1, 1, 0, 0, 8'h20); x = ex(8'h01, 8'h00, 0, 3'd0, 8'h00, 0, 0); end
                1: begin drive(0, 0, 1, 0, 0, 0, 8'h20); x = ex(8'h20, 8'h01, 0, 3'd0, 8'h00, 0, 0); end
                default: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h21, 8'h20, 0, 3'd0, 8'h00, 0, 0); end
            endcase
            sb.push_back('{exp: x, which: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL cond[%0d] got %h want %h", k, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_priority();
        sb_t         e;
        logic [29:0] x;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            x = '0;
            case (k)
                0: begin drive(0, 1, 0, 0, 1, 1, 8'h33); x = ex(8'h01, 8'h00, 0, 3'd0, 8'h00, 0, 0); end
                1: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h02, 8'h01, 0, 3'd0, 8'h00, 0, 1); end
                2: begin drive(0, 1, 0, 0, 1, 0, 8'h33); x = ex(8'h33, 8'h02, 0, 3'd0, 8'h00, 0, 1); end
                default: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h34, 8'h33, 0, 3'd1, 8'h03, 0, 1); end
            endcase
            sb.push_back('{exp: x, which: 1'b0});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL priority[%0d] got %h want %h", k, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_wait();
        sb_t         e;
        logic [29:0] x;
        apply_reset();
        for (int k = 0; k < 10; k++) begin
            x = '0;
            case (k)
                0: begin drive(0, 0, 0, 0, 0, 1, 8'h00); x = ex(8'h01, 8'h00, 0, 3'd0, 8'h00, 0, 0); end
                1, 2: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h01, 8'h01, 1, 3'd0, 8'h00, 0, 1); end
                3: begin drive(0, 0, 0, 0, 1, 0, 8'h40); x = ex(8'h40, 8'h01, 0, 3'd0, 8'h00, 0, 1); end
                4, 5: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h40, 8'h40, 1, 3'd1, 8'h02, 0, 1); end
                6: begin drive(0, 0, 0, 0, 1, 0, 8'h50); x = ex(8'h50, 8'h40, 0, 3'd1, 8'h02, 0, 1); end
                7: begin drive(1, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h00, 8'h50, 1, 3'd2, 8'h41, 0, 1); end
                8: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h01, 8'h00, 0, 3'd0, 8'h00, 0, 0); end
                default: begin drive(0, 0, 0, 0, 0, 0, 8'h00); x = ex(8'h01, 8'h01, 1, 3'd0, 8'h00, 0, 0); end
            endcase
            sb.push_back('{exp: x, which: 1'b1});
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs(e.which) !== e.exp) begin
                errors++;
                $display("FAIL mid_wait_reset[%0d] got %h want %h", k, obs(e.which), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 8'h00);
        test_reset();
        test_count_wrap();
        test_wait_states();
        test_call_ret();
        test_overflow_underflow();
        test_conditional();
        test_priority();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
